miner_tx_serializer: RTL and testbench
======================================

MINER_TX_SERIALIZER -- requirements
Module: miner_tx_serializer

Interface
REQ-001 SHALL have parameter IDLE_GAP, default 0: idle cycles with byte_valid low inserted after every accepted byte; legal range 0..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port send_data  input  1  single-cycle result-valid strobe from the miner top level.
REQ-005 SHALL have port tx_data  input  288  {hash[255:0], nonce[31:0]}; meaningful only while send_data=1.
REQ-006 SHALL have port byte_ready  input  1  downstream link accepts byte_out this cycle.
REQ-007 SHALL have port byte_out  output  8  current frame byte.
REQ-008 SHALL have port byte_valid  output  1  byte_out holds a valid byte.
REQ-009 SHALL have port busy  output  1  high from frame capture until frame end.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse at frame end.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when a send_data strobe is dropped.

Function
REQ-012 SHALL transmit frames of 38 bytes: header 0xA5, then 36 payload bytes, then 1 checksum byte.
REQ-013 SHALL send payload bytes most-significant first: tx_data[287:280] first, tx_data[7:0] last, so the nonce occupies the final 4 payload bytes.
REQ-014 SHALL set the checksum to the XOR of the 36 payload bytes; the header is excluded.
REQ-015 SHALL implement states IDLE, HEADER, PAYLOAD, CHECK, GAP.
REQ-016 IDLE: on send_data=1, capture tx_data into a 288-bit holding register, clear checksum accumulator, go to HEADER; busy=1 from the next cycle.
REQ-017 Latency: send_data high at edge k -> byte_valid=1 with byte_out=0xA5 in the cycle after edge k.
REQ-018 A transfer occurs on a rising edge where byte_valid=1 and byte_ready=1; byte_out and byte_valid SHALL stay stable until the transfer.
REQ-019 HEADER -> PAYLOAD on transfer; PAYLOAD advances a 6-bit byte index 0..35 per transfer, XORs each sent byte into the accumulator, and goes to CHECK after index 35; CHECK ends the frame on transfer.
REQ-020 When IDLE_GAP>0, every transfer except the checksum SHALL enter GAP for exactly IDLE_GAP cycles with byte_valid=0, then resume the next state.
REQ-021 When IDLE_GAP=0, the next byte SHALL be valid in the cycle immediately after a transfer; GAP is never entered.
REQ-022 Checksum transfer at edge m: frame_done=1 and busy=0 in the cycle after edge m; state IDLE; no gap after checksum.
REQ-023 send_data=1 while not in IDLE, including the cycle of the checksum transfer, SHALL be ignored: the holding register is unchanged and overrun pulses in the following cycle.
REQ-024 send_data=1 in IDLE in the cycle right after frame_done SHALL be accepted normally.
REQ-025 byte_out SHALL be 0x00 whenever byte_valid=0.
REQ-026 byte_ready while byte_valid=0 SHALL have no effect.

Reset
REQ-027 rst=1 at any edge SHALL force IDLE, index 0, accumulator 0, holding register 0, gap counter 0.
REQ-028 Outputs during and after reset: byte_out=0x00, byte_valid=0, busy=0, frame_done=0, overrun=0.
REQ-029 Reset mid-frame SHALL abandon the frame with no frame_done; a send_data arriving during reset SHALL be ignored.

Verification
REQ-030 IDLE_GAP=0, byte_ready=1, tx_data = 256'h00..01 hash with nonce 32'h12345678 -> 38 consecutive bytes A5, 31x00, 01, 12, 34, 56, 78, checksum 0x09; frame_done in the cycle after the last byte.
REQ-031 Same frame with byte_ready toggled 1,0,0,1,... -> identical byte sequence, each byte held stable across stalls, no duplicate or skipped bytes.
REQ-032 IDLE_GAP=3 -> exactly 3 invalid cycles between consecutive bytes, none after the checksum; total frame time 38+37*3=149 cycles with byte_ready=1.
REQ-033 Second send_data (nonce 32'hDEADBEEF) at payload byte 10 -> overrun pulses once and the first frame completes unchanged; send_data the cycle after frame_done -> new frame starts.
REQ-034 rst asserted at payload byte 20 -> all outputs 0 next cycle, no frame_done; a new send_data afterwards yields a full correct 38-byte frame.

Source files
------------

// File: rtl/miner_tx_serializer.sv
// rtl/miner_tx_serializer.sv - frames a 288-bit miner result as header, 36 payload bytes and XOR checksum
// Byte stream held stable until accepted; optional idle gap after every byte but the checksum.
module miner_tx_serializer #(
  parameter int IDLE_GAP = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         send_data,
  input  logic [287:0] tx_data,
  input  logic         byte_ready,
  output logic [7:0]   byte_out,
  output logic         byte_valid,
  output logic         busy,
  output logic         frame_done,
  output logic         overrun
);

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_CHECK, S_GAP} state_t;

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam logic [3:0] GAP_LOAD = 4'((IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0);

  state_t         state_q, state_d, resume_q, resume_d, adv_state;
  logic           adv;
  logic [287:0]   hold_q, hold_d;
  logic [5:0]     idx_q, idx_d;
  logic [7:0]     csum_q, csum_d;
  logic [3:0]     gap_q, gap_d;
  logic [7:0]     byte_out_q, byte_out_d;
  logic           valid_q, valid_d, busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
  logic           xfer;

  // Index 0 selects tx_data[287:280], index 35 selects tx_data[7:0].
  function automatic logic [7:0] pick(input logic [287:0] h, input logic [5:0] i);
    logic [8:0] base;
    base = {6'd35 - i, 3'b000};
    return h[base +: 8];
  endfunction

  assign xfer = valid_q & byte_ready;

  always_comb begin
    state_d   = state_q;
    resume_d  = resume_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    gap_d     = gap_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovr_d     = send_data && (state_q != S_IDLE);
    adv       = 1'b0;
    adv_state = S_IDLE;
    case (state_q)
      S_IDLE: if (send_data) begin
        hold_d  = tx_data;
        csum_d  = 8'h00;
        idx_d   = 6'd0;
        busy_d  = 1'b1;
        state_d = S_HEADER;
      end
      S_HEADER: if (xfer) begin
        adv       = 1'b1;
        adv_state = S_PAYLOAD;
      end
      S_PAYLOAD: if (xfer) begin
        csum_d = csum_q ^ byte_out_q;
        adv    = 1'b1;
        if (idx_q == 6'd35) begin
          idx_d     = 6'd0;
          adv_state = S_CHECK;
        end else begin
          idx_d     = idx_q + 6'd1;
          adv_state = S_PAYLOAD;
        end
      end
      S_CHECK: if (xfer) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      S_GAP: begin
        if (gap_q == 4'd0) state_d = resume_q;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      if (IDLE_GAP > 0) begin
        state_d  = S_GAP;
        resume_d = adv_state;
        gap_d    = GAP_LOAD;
      end else begin
        state_d  = adv_state;
      end
    end

    // Outputs are registered, so they are derived from the upcoming state.
    valid_d    = 1'b1;
    byte_out_d = 8'h00;
    case (state_d)
      S_HEADER:  byte_out_d = HDR_BYTE;
      S_PAYLOAD: byte_out_d = pick(hold_d, idx_d);
      S_CHECK:   byte_out_d = csum_d;
      default:   valid_d    = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      resume_q   <= S_IDLE;
      hold_q     <= '0;
      idx_q      <= '0;
      csum_q     <= '0;
      gap_q      <= '0;
      byte_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      resume_q   <= resume_d;
      hold_q     <= hold_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      gap_q      <= gap_d;
      byte_out_q <= byte_out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = valid_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_miner_tx_serializer.sv
// tb/tb_miner_tx_serializer.sv - random and directed checks of two serializer instances (gap 0 and gap 3)
module tb_miner_tx_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, send_data, byte_ready;
  logic [287:0] tx_data;
  logic [7:0]   bo0, bo1;
  logic         bv0, bv1, bz0, bz1, fd0, fd1, ov0, ov1;

  miner_tx_serializer #(.IDLE_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .send_data(send_data), .tx_data(tx_data), .byte_ready(byte_ready),
    .byte_out(bo0), .byte_valid(bv0), .busy(bz0), .frame_done(fd0), .overrun(ov0));

  miner_tx_serializer #(.IDLE_GAP(3)) dut1 (
    .clk(clk), .rst(rst), .send_data(send_data), .tx_data(tx_data), .byte_ready(byte_ready),
    .byte_out(bo1), .byte_valid(bv1), .busy(bz1), .frame_done(fd1), .overrun(ov1));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int mode = 0;
  int cyc  = 0;

  localparam logic [287:0] TX_A = {256'h1, 32'h12345678};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: each frame is a list of 38 bytes; a transfer pops one, then gap cycles follow.
  logic [7:0] mframe [2][38];
  int         mpos [2];
  int         mgap [2];
  bit         mact [2];
  logic [7:0] e_byte [2];
  bit         e_valid [2], e_busy [2], e_done [2], e_ovr [2];

  function automatic int gapv(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      e_done[d] = 1'b0;
      e_ovr[d]  = 1'b0;
      if (rst) begin
        mact[d] = 1'b0;
        mgap[d] = 0;
        mpos[d] = 0;
      end else if (!mact[d]) begin
        if (send_data) begin
          logic [287:0] sh;
          logic [7:0]   cs;
          cs = 8'h00;
          mframe[d][0] = 8'hA5;
          for (int i = 0; i < 36; i++) begin
            sh = tx_data >> (8 * (35 - i));
            mframe[d][1 + i] = sh[7:0];
            cs = cs ^ sh[7:0];
          end
          mframe[d][37] = cs;
          mact[d] = 1'b1;
          mpos[d] = 0;
          mgap[d] = 0;
        end
      end else begin
        if (send_data) e_ovr[d] = 1'b1;
        if (mgap[d] > 0) mgap[d]--;
        else if (byte_ready) begin
          mpos[d]++;
          if (mpos[d] == 38) begin
            mact[d]   = 1'b0;
            e_done[d] = 1'b1;
          end else begin
            mgap[d] = gapv(d);
          end
        end
      end
      e_valid[d] = mact[d] && (mgap[d] == 0);
      e_byte[d]  = e_valid[d] ? mframe[d][mpos[d]] : 8'h00;
      e_busy[d]  = mact[d];
    end
  end

  task automatic cmp(input int d, input logic [7:0] b, input logic v, input logic z,
                     input logic f, input logic o);
    check($sformatf("dut%0d byte_valid", d), {31'd0, v}, {31'd0, e_valid[d]});
    check($sformatf("dut%0d byte_out", d),   {24'd0, b}, {24'd0, e_byte[d]});
    check($sformatf("dut%0d busy", d),       {31'd0, z}, {31'd0, e_busy[d]});
    check($sformatf("dut%0d frame_done", d), {31'd0, f}, {31'd0, e_done[d]});
    check($sformatf("dut%0d overrun", d),    {31'd0, o}, {31'd0, e_ovr[d]});
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, bo0, bv0, bz0, fd0, ov0);
      cmp(1, bo1, bv1, bz1, fd1, ov1);
    end
  end

  logic [7:0] log0 [$];
  always @(posedge clk) begin
    if (!rst && bv0 && byte_ready) log0.push_back(bo0);
  end

  task automatic tick();
    @(negedge clk);
    send_data = 1'b0;
    cyc++;
    case (mode)
      0:       byte_ready = 1'b1;
      1:       byte_ready = (cyc % 3 == 0);
      default: byte_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic send(input logic [287:0] v);
    send_data = 1'b1;
    tx_data   = v;
  endtask

  function automatic logic [287:0] rnd();
    logic [287:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r = {r[255:0], 32'($urandom())};
    return r;
  endfunction

  // Hand-written expected frame for TX_A: A5, 31x00, 01, 12 34 56 78, checksum 09.
  task automatic check_log_a(input string nm);
    logic [7:0] exp [38];
    for (int i = 0; i < 38; i++) exp[i] = 8'h00;
    exp[0]  = 8'hA5;
    exp[32] = 8'h01;
    exp[33] = 8'h12;
    exp[34] = 8'h34;
    exp[35] = 8'h56;
    exp[36] = 8'h78;
    exp[37] = 8'h09;
    check({nm, " length"}, 32'(log0.size()), 32'd38);
    for (int i = 0; i < 38 && i < log0.size(); i++)
      check($sformatf("%s byte%0d", nm, i), {24'd0, log0[i]}, {24'd0, exp[i]});
  endtask

  task automatic wait_idle(input string nm, input int limit);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((bz0 || bz1) && n < limit);
    if (bz0 || bz1) check({nm, " idle timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_log(input string nm, input int cnt, input int limit);
    int n;
    n = 0;
    while (log0.size() < cnt && n < limit) begin
      tick();
      n++;
    end
    if (log0.size() != cnt) check({nm, " byte count"}, 32'(log0.size()), 32'(cnt));
  endtask

  initial begin
    int c0, c1, ovc;
    rst = 1'b1; send_data = 1'b0; byte_ready = 1'b1; tx_data = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset byte_valid", {31'd0, bv0}, 32'd0);
    check("reset busy", {31'd0, bz1}, 32'd0);
    tick();
    rst = 1'b0;

    // Plain frame with continuous ready; gap-3 instance must take 149 busy cycles.
    log0.delete();
    tick(); send(TX_A);
    c0 = 0; c1 = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (i == 0) begin
        check("first byte valid", {31'd0, bv0}, 32'd1);
        check("first byte header", {24'd0, bo0}, 32'hA5);
      end
      if (bz0) c0++;
      if (bz1) c1++;
      if (fd1) break;
    end
    check("gap0 frame cycles", 32'(c0), 32'd38);
    check("gap3 frame cycles", 32'(c1), 32'd149);
    check_log_a("frame ready1");
    wait_idle("frame ready1", 50);

    // Same frame with ready stalling 1,0,0 pattern.
    log0.delete(); mode = 1;
    tick(); send(TX_A);
    wait_idle("frame toggle", 2000);
    check_log_a("frame toggle");

    // Second strobe mid-payload is dropped; strobe during frame_done cycle starts a new frame.
    log0.delete(); mode = 0;
    tick(); send(TX_A);
    wait_log("overrun setup", 11, 100);
    send({256'hCAFE, 32'hDEADBEEF});
    ovc = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ov0) ovc++;
      if (fd0) break;
    end
    check("overrun pulses", 32'(ovc), 32'd1);
    check_log_a("frame overrun");
    send(rnd());
    tick();
    check("restart valid", {31'd0, bv0}, 32'd1);
    check("restart header", {24'd0, bo0}, 32'hA5);
    wait_idle("restart", 400);

    // Random traffic including strobes while busy.
    mode = 2;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 29) == 0) send(rnd());
    end
    mode = 0;
    wait_idle("random", 400);

    // Reset mid-frame with a concurrent strobe, then a clean frame.
    log0.delete();
    tick(); send(TX_A);
    wait_log("reset setup", 21, 100);
    rst = 1'b1;
    send(rnd());
    tick();
    rst = 1'b0;
    check("post reset valid", {31'd0, bv0}, 32'd0);
    check("post reset busy", {31'd0, bz0}, 32'd0);
    check("post reset done", {31'd0, fd0}, 32'd0);
    repeat (3) tick();
    log0.delete();
    send(TX_A);
    wait_idle("after reset", 400);
    check_log_a("frame after reset");

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
